// File: rtl/ce_equalizer.sv
// Conjugate-multiply equalizer: averages 2^AVG_LOG2 channel estimates into H,
// then multiplies each data symbol by conj(H) through a two-stage saturating pipeline.
//
//   state | meaning
//   IDLE  | waiting for io_start; estimates and data ignored
//   TRAIN | accumulating estimates; data dropped
//   EQ    | H held; each data symbol equalized
module ce_equalizer #(
  parameter int WIDTH    = 40,
  parameter int FRAC     = 20,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_est_valid,
  input  logic [WIDTH-1:0] io_est_real,
  input  logic [WIDTH-1:0] io_est_imag,
  input  logic             io_in_valid,
  input  logic [WIDTH-1:0] io_in_real,
  input  logic [WIDTH-1:0] io_in_imag,
  output logic             io_out_valid,
  output logic [WIDTH-1:0] io_out_real,
  output logic [WIDTH-1:0] io_out_imag,
  output logic             io_trained
);

  localparam int ACC_W   = WIDTH + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int SUM_W   = 2 * WIDTH + 1;
  localparam int NUM_EST = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    EQ    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0]  est_re, est_im, in_re, in_im;
  logic signed [ACC_W-1:0]  acc_re, acc_im, acc_re_sum, acc_im_sum;
  logic        [CNT_W-1:0]  est_cnt;
  logic signed [WIDTH-1:0]  h_re, h_im;
  logic                     est_last, train_clr, est_take, h_load, in_take;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [SUM_W-1:0]  sum_re, sum_im, sh_re, sh_im;

  assign est_re = io_est_real;
  assign est_im = io_est_imag;
  assign in_re  = io_in_real;
  assign in_im  = io_in_imag;

  assign acc_re_sum = acc_re + ACC_W'(est_re);
  assign acc_im_sum = acc_im + ACC_W'(est_im);
  assign est_last   = (est_cnt == CNT_W'(NUM_EST - 1));
  assign in_take    = io_in_valid && (state == EQ);
  assign io_trained = (state == EQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start pulse always wins over a coincident estimate.
  always_comb begin
    state_nxt = state;
    train_clr = 1'b0;
    est_take  = 1'b0;
    h_load    = 1'b0;
    case (state)
      IDLE: begin
        if (io_start) begin
          state_nxt = TRAIN;
          train_clr = 1'b1;
        end
      end
      TRAIN: begin
        if (io_start) begin
          train_clr = 1'b1;
        end else if (io_est_valid) begin
          est_take = 1'b1;
          if (est_last) begin
            h_load    = 1'b1;
            state_nxt = EQ;
          end
        end
      end
      EQ: begin
        if (io_start) begin
          state_nxt = TRAIN;
          train_clr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_re  <= '0;
      acc_im  <= '0;
      est_cnt <= '0;
      h_re    <= '0;
      h_im    <= '0;
    end else begin
      if (train_clr) begin
        acc_re  <= '0;
        acc_im  <= '0;
        est_cnt <= '0;
      end else if (est_take) begin
        acc_re  <= acc_re_sum;
        acc_im  <= acc_im_sum;
        est_cnt <= est_cnt + CNT_W'(1);
      end
      // H stays put across a restart until the new average is complete.
      if (h_load) begin
        h_re <= WIDTH'(acc_re_sum >>> AVG_LOG2);
        h_im <= WIDTH'(acc_im_sum >>> AVG_LOG2);
      end
    end
  end

  // Products carry the H of their own cycle, so later H updates cannot disturb them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ir     <= '0;
      p_ri     <= '0;
    end else begin
      s1_valid <= in_take;
      if (in_take) begin
        p_rr <= PROD_W'(in_re) * PROD_W'(h_re);
        p_ii <= PROD_W'(in_im) * PROD_W'(h_im);
        p_ir <= PROD_W'(in_im) * PROD_W'(h_re);
        p_ri <= PROD_W'(in_re) * PROD_W'(h_im);
      end
    end
  end

  always_comb begin
    sum_re = SUM_W'(p_rr) + SUM_W'(p_ii);
    sum_im = SUM_W'(p_ir) - SUM_W'(p_ri);
    sh_re  = sum_re >>> FRAC;
    sh_im  = sum_im >>> FRAC;
  end

  function automatic logic [WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-WIDTH:0] top;
    top = v[SUM_W-1:WIDTH-1];
    if (&top || ~|top) return v[WIDTH-1:0];
    else if (v[SUM_W-1]) return {1'b1, {(WIDTH-1){1'b0}}};
    else return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      io_out_real  <= '0;
      io_out_imag  <= '0;
    end else begin
      io_out_valid <= s1_valid;
      if (s1_valid) begin
        io_out_real <= sat(sh_re);
        io_out_imag <= sat(sh_im);
      end
    end
  end

endmodule
